// File: rtl/write_back_pkg.sv
// write_back_pkg: shared types and constants for the write-back stage.
//   wb_state_t : stage FSM state
//   regind_t   : register index (default width)
//   regval_t   : register / memory data word (default width)
//   flags_t    : {carry, negative, overflow, zero}
//   REG_ZERO   : discard register index; writes to it are suppressed
package write_back_pkg;

    localparam int WB_REG_BITS  = 5;
    localparam int WB_DATA_BITS = 32;

    typedef logic [WB_REG_BITS-1:0]  regind_t;
    typedef logic [WB_DATA_BITS-1:0] regval_t;

    localparam regind_t REG_ZERO = '0;

    typedef struct packed {
        logic carry;
        logic negative;
        logic overflow;
        logic zero;
    } flags_t;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_PRIMARY = 2'd1,
        WB_UPPER   = 2'd2,
        WB_STORE   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/write_back.sv
// write_back: final pipeline stage. Captures the execute bundle and retires it:
// a primary register write plus flags, an optional upper-word write to dest+1,
// or a memory store held until the memory drops mem_waitrequest.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   in_valid / in_hold      : bundle handshake with execute (hold = stall)
//   pc ... store_data       : execute bundle fields (pc is trace-only)
//   reg_we/reg_index/reg_value : register-file write port
//   flags_we/flags_value    : flags write port
//   mem_write/mem_address/mem_data/mem_waitrequest : data-memory store port
module write_back
    import write_back_pkg::*;
#(
    parameter int REG_BITS  = WB_REG_BITS,
    parameter int DATA_BITS = WB_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_hold,
    input  logic [DATA_BITS-1:0] pc,
    input  logic [REG_BITS-1:0]  destination_register,
    input  logic                 is_writing_memory,
    input  logic [3:0]           flags,
    input  logic [DATA_BITS-1:0] destination_value,
    input  logic                 has_upper_value,
    input  logic [DATA_BITS-1:0] upper_value,
    input  logic                 has_flushed,
    input  logic [DATA_BITS-1:0] store_data,
    output logic                 reg_we,
    output logic [REG_BITS-1:0]  reg_index,
    output logic [DATA_BITS-1:0] reg_value,
    output logic                 flags_we,
    output logic [3:0]           flags_value,
    output logic                 mem_write,
    output logic [DATA_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0] mem_data,
    input  logic                 mem_waitrequest
);

    wb_state_t            state_q, state_d;
    logic [REG_BITS-1:0]  dest_q;
    logic [DATA_BITS-1:0] value_q;
    logic [DATA_BITS-1:0] upper_q;
    logic [DATA_BITS-1:0] sdata_q;
    logic                 has_upper_q;
    flags_t               flags_q;

    logic                 done;     // stage will be free at the next edge
    logic                 accept;
    logic                 wr_req;

    // pc is only meaningful for tracing; keep it from tripping unused-signal lint.
    logic unused_pc;
    assign unused_pc = ^pc;

    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        wr_req      = 1'b0;
        reg_index   = '0;
        reg_value   = '0;
        flags_we    = 1'b0;
        flags_value = '0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data    = '0;

        case (state_q)
            WB_IDLE: done = 1'b1;
            WB_PRIMARY: begin
                wr_req      = 1'b1;
                reg_index   = dest_q;
                reg_value   = value_q;
                flags_we    = 1'b1;
                flags_value = flags_q;
                if (has_upper_q) begin
                    state_d = WB_UPPER;
                end else begin
                    state_d = WB_IDLE;
                    done    = 1'b1;
                end
            end
            WB_UPPER: begin
                wr_req    = 1'b1;
                reg_index = dest_q + REG_BITS'(1);   // wraps to 0 -> suppressed below
                reg_value = upper_q;
                state_d   = WB_IDLE;
                done      = 1'b1;
            end
            WB_STORE: begin
                mem_write   = 1'b1;
                mem_address = value_q;
                mem_data    = sdata_q;
                if (!mem_waitrequest) begin
                    state_d = WB_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        // Hold only while the stage stays busy past the next edge, so a
        // bundle can be taken on the same edge the current one finishes.
        in_hold = in_valid && !done;
        accept  = in_valid && done;

        if (accept) begin
            if (has_flushed)            state_d = WB_IDLE;
            else if (is_writing_memory) state_d = WB_STORE;
            else                        state_d = WB_PRIMARY;
        end

        reg_we = wr_req && (reg_index != REG_BITS'(REG_ZERO));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WB_IDLE;
            dest_q      <= '0;
            value_q     <= '0;
            upper_q     <= '0;
            sdata_q     <= '0;
            has_upper_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dest_q      <= destination_register;
                value_q     <= destination_value;
                upper_q     <= upper_value;
                sdata_q     <= store_data;
                has_upper_q <= has_upper_value;
                flags_q     <= flags_t'(flags);
            end
        end
    end

endmodule
